measure_sequencer: RTL

Sequencing controller for the frequency-meter counter datapath. It synchronises an asynchronous trigger input, then drives the counter's control strobes through a fixed clear, gate, latch and display cycle: `clr` → `count` (gate window) → `save` → `disp`. It also supports an auto-repeat mode and early termination when the counter overflows. It sits between the trigger/switch inputs and the counter, latch and display blocks.

---
 rtl/freq_meter_pkg.sv | 34 +++
 rtl/in_sync_edge.sv | 38 +++
 rtl/measure_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency-meter blocks:
//   - meas_state_e : measurement sequencer state encoding (3 bits)
//   - DEFAULT_GATE_CYCLES / DEFAULT_HOLD_CYCLES : default window lengths
//   - clog2()      : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GATE  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4
    } meas_state_e;

    localparam int DEFAULT_GATE_CYCLES = 100;
    localparam int DEFAULT_HOLD_CYCLES = 50;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/in_sync_edge.sv
// -----------------------------------------------------------------------------
// in_sync_edge
// Brings an asynchronous level into the clk domain through two flops, delays
// it by one more flop and flags the synchronised rising edge for one cycle.
// All flops reset synchronously to 0, so a level that is already high when
// reset releases still yields exactly one edge.
// Ports:
//   clk_i   : system clock
//   reset_i : synchronous active-high reset
//   async_i : asynchronous input level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module in_sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/measure_sequencer.sv
// -----------------------------------------------------------------------------
// measure_sequencer
// Drives the frequency-meter counter datapath through one measurement:
// CLEAR (clr) -> GATE (count, GATE_CYCLES long) -> LATCH (save) ->
// SHOW (disp, HOLD_CYCLES long). A measurement starts on a rising edge of
// the asynchronous trigger; with auto high, SHOW loops straight back to
// CLEAR. An overflow during GATE cuts the gate short and is remembered in
// ovf_flag until the next CLEAR.
// Ports:
//   clk      : system clock
//   reset    : synchronous active-high reset
//   in       : asynchronous measurement trigger (rising edge starts)
//   auto     : continuous mode, quasi-static
//   ovf      : datapath counter overflow, only looked at in GATE
//   clr      : counter clear strobe (CLEAR)
//   count    : counter gate enable (GATE)
//   save     : result latch strobe (LATCH)
//   disp     : display enable (SHOW)
//   busy     : high whenever the sequencer is not IDLE
//   ovf_flag : last measurement ended by overflow
// -----------------------------------------------------------------------------
module measure_sequencer
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int TW = clog2(((GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES) + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic auto,
    input  logic ovf,
    output logic clr,
    output logic count,
    output logic save,
    output logic disp,
    output logic busy,
    output logic ovf_flag
);

    localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    meas_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ovf_flag_q, ovf_flag_d;
    logic          trig;

    in_sync_edge u_in_sync_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .async_i (in),
        .rise_o  (trig)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    // The timer is loaded on the edge entering GATE/SHOW and forced to 0 on
    // every exit, so it sits at 0 in IDLE, CLEAR and LATCH and never wraps.
    // Triggers seen outside IDLE are simply dropped.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ovf_flag_d = ovf_flag_q;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (trig) begin
                    state_d    = ST_CLEAR;
                    ovf_flag_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_GATE;
                timer_d = GATE_LOAD;
            end
            ST_GATE: begin
                if (ovf) begin
                    // Overflow wins even when the window also expires now.
                    state_d    = ST_LATCH;
                    timer_d    = '0;
                    ovf_flag_d = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = ST_LATCH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LATCH: begin
                state_d = ST_SHOW;
                timer_d = HOLD_LOAD;
            end
            ST_SHOW: begin
                if (timer_q == '0) begin
                    timer_d = '0;
                    if (auto) begin
                        state_d    = ST_CLEAR;
                        ovf_flag_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign clr      = (state_q == ST_CLEAR);
    assign count    = (state_q == ST_GATE);
    assign save     = (state_q == ST_LATCH);
    assign disp     = (state_q == ST_SHOW);
    assign busy     = (state_q != ST_IDLE);
    assign ovf_flag = ovf_flag_q;

endmodule
